// File: rtl/battle_datapath.sv
// rtl/battle_datapath.sv - HP registers, serial shift-add damage multiplier and saturating write-back
module battle_datapath #(
    parameter int HP_W = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_ai_hp_i,
    input  logic            load_p_hp_i,
    input  logic [HP_W-1:0] ai_hp_init_i,
    input  logic [HP_W-1:0] p_hp_init_i,
    input  logic            apply_ai_damage_i,
    input  logic            apply_p_damage_i,
    input  logic            active_trainer_i,
    input  logic            target_i,
    input  logic [5:0]      p_power_i,
    input  logic [5:0]      ai_power_i,
    input  logic [3:0]      p_atk_i,
    input  logic [3:0]      ai_atk_i,
    output logic [HP_W-1:0] p_hp_o,
    output logic [HP_W-1:0] ai_hp_o,
    output logic            p_fainted_o,
    output logic            ai_fainted_o,
    output logic [7:0]      last_dmg_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {IDLE, MUL, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d;
    logic [HP_W-1:0] ai_hp_q, ai_hp_d;
    logic [7:0]      last_dmg_q, last_dmg_d;
    logic            err_q, err_d;
    logic [9:0]      acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [5:0]      pow_q, pow_d;
    logic [3:0]      atk_q, atk_d;
    logic            tgt_q, tgt_d;

    logic [7:0]      dmg_w;
    logic [HP_W-1:0] dmg_ext;
    logic [HP_W-1:0] hp_sel;
    logic [HP_W-1:0] hp_new;
    logic            any_strobe;

    // Damage is the product scaled by 1/4 plus one; 945 max keeps it within 8 bits.
    assign dmg_w      = 8'((acc_q >> 2) + 10'd1);
    assign dmg_ext    = HP_W'(dmg_w);
    assign hp_sel     = tgt_q ? ai_hp_q : p_hp_q;
    assign hp_new     = (hp_sel > dmg_ext) ? (hp_sel - dmg_ext) : '0;
    assign any_strobe = load_ai_hp_i | load_p_hp_i | apply_ai_damage_i | apply_p_damage_i;

    // State and datapath registers; reset aborts any hit in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            p_hp_q     <= '0;
            ai_hp_q    <= '0;
            last_dmg_q <= '0;
            err_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pow_q      <= '0;
            atk_q      <= '0;
            tgt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_hp_q     <= p_hp_d;
            ai_hp_q    <= ai_hp_d;
            last_dmg_q <= last_dmg_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pow_q      <= pow_d;
            atk_q      <= atk_d;
            tgt_q      <= tgt_d;
        end
    end

    // Next-state: strobe qualification in IDLE, one multiplier bit per MUL cycle, saturating write.
    always_comb begin
        state_d    = state_q;
        p_hp_d     = p_hp_q;
        ai_hp_d    = ai_hp_q;
        last_dmg_d = last_dmg_q;
        err_d      = 1'b0;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pow_d      = pow_q;
        atk_d      = atk_q;
        tgt_d      = tgt_q;
        case (state_q)
            IDLE: begin
                if (load_ai_hp_i) ai_hp_d = ai_hp_init_i;
                if (load_p_hp_i)  p_hp_d  = p_hp_init_i;
                if (apply_ai_damage_i && apply_p_damage_i) begin
                    err_d = 1'b1;
                end else if (apply_ai_damage_i) begin
                    if (!active_trainer_i && target_i) begin
                        pow_d   = p_power_i;
                        atk_d   = p_atk_i;
                        tgt_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (apply_p_damage_i) begin
                    if (active_trainer_i && !target_i) begin
                        pow_d   = ai_power_i;
                        atk_d   = ai_atk_i;
                        tgt_d   = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MUL: begin
                if (any_strobe) err_d = 1'b1;
                if (atk_q[cnt_q]) acc_d = acc_q + ({4'b0, pow_q} << cnt_q);
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                if (any_strobe) err_d = 1'b1;
                last_dmg_d = dmg_w;
                if (tgt_q) ai_hp_d = hp_new;
                else       p_hp_d  = hp_new;
                state_d = DONE;
            end
            DONE: begin
                if (any_strobe) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign p_hp_o       = p_hp_q;
    assign ai_hp_o      = ai_hp_q;
    assign p_fainted_o  = (p_hp_q == '0);
    assign ai_fainted_o = (ai_hp_q == '0);
    assign last_dmg_o   = last_dmg_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_battle_datapath.sv
// tb/tb_battle_datapath.sv - vector table plus scoreboard bench for battle_datapath
module tb_battle_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_ai = 1'b0, load_p = 1'b0;
    logic [7:0] ai_init = '0, p_init = '0;
    logic       apply_ai = 1'b0, apply_p = 1'b0;
    logic       active = 1'b0, tgt = 1'b0;
    logic [5:0] p_power = '0, ai_power = '0;
    logic [3:0] p_atk = '0, ai_atk = '0;
    logic [7:0] p_hp, ai_hp, last_dmg;
    logic       p_fainted, ai_fainted, busy, done, err;

    battle_datapath #(.HP_W(8)) dut (
        .clk_i(clk), .reset_i(reset),
        .load_ai_hp_i(load_ai), .load_p_hp_i(load_p),
        .ai_hp_init_i(ai_init), .p_hp_init_i(p_init),
        .apply_ai_damage_i(apply_ai), .apply_p_damage_i(apply_p),
        .active_trainer_i(active), .target_i(tgt),
        .p_power_i(p_power), .ai_power_i(ai_power),
        .p_atk_i(p_atk), .ai_atk_i(ai_atk),
        .p_hp_o(p_hp), .ai_hp_o(ai_hp),
        .p_fainted_o(p_fainted), .ai_fainted_o(ai_fainted),
        .last_dmg_o(last_dmg), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ld_ai;
        bit         ld_p;
        bit         same;
        logic [7:0] ai_init;
        logic [7:0] p_init;
        bit         side;
        logic [5:0] pw;
        logic [3:0] at;
        logic [7:0] e_dmg;
        logic [7:0] e_ai;
        logic [7:0] e_p;
    } vec_t;

    typedef struct {
        logic [7:0] dmg;
        logic [7:0] ai;
        logic [7:0] p;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] mdl_dmg(input logic [5:0] pw, input logic [3:0] at);
        int prod;
        prod = int'(pw) * int'(at);
        return 8'((prod / 4) + 1);
    endfunction

    function automatic logic [7:0] mdl_sat(input logic [7:0] hp, input logic [7:0] d);
        return (hp > d) ? hp - d : 8'd0;
    endfunction

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            chk("last_dmg", 32'(last_dmg), 32'(e.dmg));
            chk("ai_hp", 32'(ai_hp), 32'(e.ai));
            chk("p_hp", 32'(p_hp), 32'(e.p));
            chk("ai_fainted", 32'(ai_fainted), 32'(e.ai == 8'd0));
            chk("p_fainted", 32'(p_fainted), 32'(e.p == 8'd0));
        end
    endtask

    task automatic scramble();
        p_power  = 6'($urandom);
        ai_power = 6'($urandom);
        p_atk    = 4'($urandom);
        ai_atk   = 4'($urandom);
        active   = 1'($urandom);
        tgt      = 1'($urandom);
    endtask

    task automatic drive_apply(input bit side, input logic [5:0] pw, input logic [3:0] at);
        scramble();
        if (side == 1'b0) begin
            apply_ai = 1'b1; active = 1'b0; tgt = 1'b1; p_power = pw; p_atk = at;
        end else begin
            apply_p = 1'b1; active = 1'b1; tgt = 1'b0; ai_power = pw; ai_atk = at;
        end
    endtask

    // Starts and ends at posedge+1 with all strobes low.
    task automatic do_hit(input vec_t v);
        exp_t e;
        ai_init = v.ai_init;
        p_init  = v.p_init;
        if ((v.ld_ai || v.ld_p) && !v.same) begin
            load_ai = v.ld_ai; load_p = v.ld_p;
            @(posedge clk); #1;
            load_ai = 1'b0; load_p = 1'b0;
        end
        if (v.same) begin
            load_ai = v.ld_ai; load_p = v.ld_p;
        end
        drive_apply(v.side, v.pw, v.at);
        e.dmg = v.e_dmg; e.ai = v.e_ai; e.p = v.e_p;
        sb_q.push_back(e);
        @(posedge clk); #1;
        apply_ai = 1'b0; apply_p = 1'b0; load_ai = 1'b0; load_p = 1'b0;
        scramble();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(k <= 5));
            chk("done", 32'(done), 32'(k == 5));
            if (k == 0) chk("err_accept", 32'(err), 32'(0));
            if (k == 5) sb_check();
        end
        @(posedge clk); #1;
    endtask

    task automatic reject(input string nm, input bit a_ai, input bit a_p, input bit act, input bit tg);
        apply_ai = a_ai; apply_p = a_p; active = act; tgt = tg;
        @(posedge clk); #1;
        apply_ai = 1'b0; apply_p = 1'b0;
        @(negedge clk);
        chk({nm, "_err"}, 32'(err), 32'(1));
        chk({nm, "_busy"}, 32'(busy), 32'(0));
        @(negedge clk);
        chk({nm, "_err_clr"}, 32'(err), 32'(0));
        chk({nm, "_ai_hp"}, 32'(ai_hp), 32'(80));
        chk({nm, "_p_hp"}, 32'(p_hp), 32'(90));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        bit   seen_done;
        logic [7:0] a0, p0, d;

        tbl[0] = '{1, 1, 0, 100, 200, 0, 40, 5, 51, 49, 200};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 40, 5, 51, 0, 200};
        tbl[2] = '{0, 1, 0, 0, 255, 1, 63, 15, 237, 0, 18};
        tbl[3] = '{1, 1, 1, 10, 18, 1, 1, 0, 1, 10, 17};
        tbl[4] = '{1, 0, 0, 200, 0, 0, 63, 8, 127, 73, 17};
        tbl[5] = '{0, 0, 0, 0, 0, 1, 17, 1, 5, 73, 12};
        tbl[6] = '{0, 1, 1, 0, 5, 1, 17, 1, 5, 73, 0};
        tbl[7] = '{1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Load latency, then asynchronous reset in mid-cycle.
        load_ai = 1'b1; load_p = 1'b1; ai_init = 8'd100; p_init = 8'd200;
        @(posedge clk); #1;
        load_ai = 1'b0; load_p = 1'b0;
        chk("load_ai_hp", 32'(ai_hp), 32'(100));
        chk("load_p_hp", 32'(p_hp), 32'(200));
        chk("load_ai_fainted", 32'(ai_fainted), 32'(0));
        #2 reset = 1'b1;
        #1;
        chk("rst_ai_hp", 32'(ai_hp), 32'(0));
        chk("rst_p_hp", 32'(p_hp), 32'(0));
        chk("rst_last_dmg", 32'(last_dmg), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_ai_fainted", 32'(ai_fainted), 32'(1));
        chk("rst_p_fainted", 32'(p_fainted), 32'(1));
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_hit(tbl[i]);

        // Rejections in IDLE leave HP untouched.
        load_ai = 1'b1; load_p = 1'b1; ai_init = 8'd80; p_init = 8'd90;
        @(posedge clk); #1;
        load_ai = 1'b0; load_p = 1'b0;
        reject("both", 1'b1, 1'b1, 1'b0, 1'b1);
        reject("bad_target", 1'b1, 1'b0, 1'b0, 1'b0);
        reject("bad_trainer", 1'b0, 1'b1, 1'b0, 1'b0);

        // Strobe at E2 and load at E3 of an in-flight hit.
        load_ai = 1'b1; load_p = 1'b1; ai_init = 8'd150; p_init = 8'd60;
        @(posedge clk); #1;
        load_ai = 1'b0; load_p = 1'b0;
        drive_apply(1'b0, 6'd40, 4'd5);
        e.dmg = 8'd51; e.ai = 8'd99; e.p = 8'd60;
        sb_q.push_back(e);
        @(posedge clk); #1;
        apply_ai = 1'b0;
        @(posedge clk); #1;
        apply_p = 1'b1; active = 1'b1; tgt = 1'b0;
        @(posedge clk); #1;
        apply_p = 1'b0; load_p = 1'b1; p_init = 8'd7;
        @(negedge clk);
        chk("busy_strobe_err", 32'(err), 32'(1));
        @(posedge clk); #1;
        load_p = 1'b0;
        @(negedge clk);
        chk("busy_load_err", 32'(err), 32'(1));
        chk("busy_load_p_hp", 32'(p_hp), 32'(60));
        @(negedge clk);
        chk("busy_err_clr", 32'(err), 32'(0));
        chk("busy_e4", 32'(busy), 32'(1));
        @(negedge clk);
        chk("busy_done", 32'(done), 32'(1));
        sb_check();
        @(negedge clk);
        chk("busy_done_clr", 32'(done), 32'(0));
        chk("busy_fall", 32'(busy), 32'(0));
        @(posedge clk); #1;

        // Reset at E3 aborts the hit.
        drive_apply(1'b0, 6'd40, 4'd5);
        @(posedge clk); #1;
        apply_ai = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_ai_hp", 32'(ai_hp), 32'(0));
        @(negedge clk); reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen_done), 32'(0));
        @(posedge clk); #1;
        v = '{1, 1, 0, 100, 33, 0, 40, 5, 51, 49, 33};
        do_hit(v);

        // Random hits checked against an arithmetic model.
        for (int i = 0; i < 6; i++) begin
            a0 = 8'($urandom_range(1, 255));
            p0 = 8'($urandom_range(1, 255));
            v.ld_ai = 1; v.ld_p = 1; v.same = i[0];
            v.ai_init = a0; v.p_init = p0;
            v.side = 1'($urandom);
            v.pw = 6'($urandom); v.at = 4'($urandom);
            d = mdl_dmg(v.pw, v.at);
            v.e_dmg = d;
            v.e_ai = v.side ? a0 : mdl_sat(a0, d);
            v.e_p  = v.side ? mdl_sat(p0, d) : p0;
            do_hit(v);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/battle_datapath.md
# battle_datapath

Battle datapath that answers the turn-sequencing control FSM. It holds both Pokémon HP registers and accepts the FSM's load and apply-damage strobes. For each damage strobe it computes the hit with a serial shift-add multiplier and writes the saturated result back to the target's HP, reporting completion with a `busy`/`done` handshake. The HP values and faint flags feed back to the FSM's victory and loss decisions.

## Interface
- `HP_W`, default 8: HP register width. Must be ≥ 8.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load_ai_hp` in 1: one-cycle strobe that loads `ai_hp_init` into the AI HP register.
- `load_p_hp` in 1: one-cycle strobe that loads `p_hp_init` into the player HP register.
- `ai_hp_init`, `p_hp_init` in HP_W: load values.
- `apply_ai_damage` in 1: strobe for player attacks AI. Requires `active_trainer`=0 and `target`=1.
- `apply_p_damage` in 1: strobe for AI attacks player. Requires `active_trainer`=1 and `target`=0.
- `active_trainer` in 1: selects the attacker (0 player, 1 AI).
- `target` in 1: selects the defender (0 player, 1 AI).
- `p_power`, `ai_power` in 6: move power of each side.
- `p_atk`, `ai_atk` in 4: attack stat of each side.
- `p_hp`, `ai_hp` out HP_W: current HP registers.
- `p_fainted`, `ai_fainted` out 1: combinational, asserted when the corresponding HP is 0.
- `last_dmg` out 8: damage of the most recent completed hit.
- `busy` out 1: asserted while a hit is in flight.
- `done` out 1: one-cycle pulse when a hit has been written.
- `err` out 1: one-cycle pulse when a strobe is rejected.

## Operation
- FSM states are IDLE, MUL, WRITE and DONE.
  - `busy` is 1 in MUL, WRITE and DONE.
  - `done` is 1 only in DONE.
- **Loads**
  - Accepted in IDLE only. They take effect at the sampling edge.
  - `load_ai_hp` and `load_p_hp` may be asserted together, and both registers load.
  - A load in any other state is ignored and pulses `err`.
- **Apply strobes**
  - Sampled in IDLE only.
  - A valid apply latches the attacker's power and atk, plus the target, then goes to MUL with the accumulator cleared and `cnt`=0. Later input changes have no effect on the hit in flight.
  - The following cases are rejected with no state change and an `err` pulse:
    - both apply strobes high in the same cycle;
    - `active_trainer` or `target` not matching the strobe;
    - an apply strobe in MUL, WRITE or DONE.
  - A load together with a valid apply in IDLE: the load is performed and the apply is accepted. The damage applies to the freshly loaded value.
- **MUL** runs for 4 cycles.
  - Each cycle: if `atk[cnt]` is 1, add `power << cnt` to the 10-bit accumulator. Then increment `cnt`.
  - After `cnt`=3, go to WRITE.
- **WRITE**
  - Computes `dmg = (product >> 2) + 1`, 8 bits. The maximum is 63·15 = 945, giving 237, so no overflow.
  - The target HP becomes `hp − dmg` if `hp > dmg`, else 0 (saturating; no wrap).
  - `last_dmg` is set to `dmg`. Go to DONE.
- **DONE**: unconditionally returns to IDLE on the next edge.
- `err` is registered: it is high in the cycle after the offending edge.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE;
  - `p_hp`, `ai_hp`, `last_dmg` = 0;
  - `busy`, `done`, `err` = 0;
  - `p_fainted` and `ai_fainted` = 1 because HP is 0.
- **Reset during a hit**: the hit is aborted, with no HP write and no `done`.
- **Hit latency**, with the valid strobe sampled at edge E0:
  - `busy` rises after E0.
  - MUL runs over E1–E4.
  - The HP and `last_dmg` update at E5.
  - `done` is high between E5 and E6.
  - `busy` falls after E6.
- **Next acceptance**: the earliest next strobe is sampled at E7, so the minimum issue interval is 7 cycles.
- **Load latency**: a load updates HP at the sampling edge. The faint flag follows in the same cycle.
- A strobe held high for several cycles produces one hit. The extra cycles during `busy` are rejected with `err`. The control FSM issues single-cycle strobes.

## Test plan
- **Reset value check**
  - Stimulus: assert `reset` asynchronously mid-cycle.
  - Required: all outputs clear immediately; `p_fainted` = `ai_fainted` = 1.
- **Player hit, exact timing**
  - Stimulus: load `ai_hp_init`=100. Then apply `apply_ai_damage` with `p_power`=40, `p_atk`=5, `active_trainer`=0, `target`=1.
  - Required: `ai_hp`=49 and `last_dmg`=51 at E5; `done` high exactly one cycle; `busy` high E0→E6.
- **Saturation to zero**
  - Stimulus: repeat the player hit with `ai_hp` at 49.
  - Required: `ai_hp`=0, `ai_fainted`=1, `p_hp` unchanged.
- **AI hit at maximum operands**
  - Stimulus: `p_hp_init`=255, then `apply_p_damage` with `ai_power`=63, `ai_atk`=15.
  - Required: `last_dmg`=237, `p_hp`=18.
- **Rejection cases**
  - Stimuli:
    - both apply strobes together;
    - `apply_ai_damage` with `target`=0;
    - a strobe at E2 of an in-flight hit.
  - Required: each produces a one-cycle `err`; no HP change beyond the in-flight hit.
- **Reset mid-hit**
  - Stimulus: assert `reset` at E3 of a hit, then release.
  - Required: no `done`, HP = 0, FSM in IDLE; the next valid strobe completes normally.
